// File: rtl/step_decoder.sv
// Registered 3-to-8 step decoder: binary step index in, one-hot step out held for DWELL cycles.
// Optional break-before-make gap cycle between scan steps when STEP_DECODER_GAP_EN is defined.
module step_decoder #(
   parameter int DWELL = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [2:0] in_code,
   output logic       in_ready,
   input  logic       scan,
   input  logic       clear,
   output logic [7:0] step,
   output logic       step_valid,
   output logic       wrap
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);

`ifdef STEP_DECODER_GAP_EN
   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1} state_t;
`endif

   state_t           r_state;
   state_t           w_stateNext;
   logic [2:0]       r_code;
   logic [2:0]       w_codeNext;
   logic [2:0]       w_codeInc;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cntNext;
   logic [7:0]       r_step;
   logic [7:0]       w_stepNext;
   logic             r_stepValid;
   logic             r_wrap;
   logic             w_wrapNext;
   logic             w_expire;

   function automatic logic [7:0] oneHot(input logic [2:0] idx);
      oneHot = 8'd1 << idx;
   endfunction

   assign w_codeInc = r_code + 3'd1;
   assign w_expire  = (r_state == HOLD) && (r_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      if (clear) begin
         w_stateNext = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  w_stateNext = HOLD;
               end
            end
            HOLD: begin
               if (w_expire) begin
`ifdef STEP_DECODER_GAP_EN
                  w_stateNext = scan ? GAP : IDLE;
`else
                  w_stateNext = scan ? HOLD : IDLE;
`endif
               end
            end
`ifdef STEP_DECODER_GAP_EN
            GAP: begin
               w_stateNext = HOLD;
            end
`endif
            default: begin
               w_stateNext = IDLE;
            end
         endcase
      end
   end

   // scan is only looked at on the expiry cycle, so mid-dwell toggles are harmless
   always_comb begin
      w_codeNext = r_code;
      w_cntNext  = r_cnt;
      w_stepNext = r_step;
      w_wrapNext = 1'b0;
      if (clear) begin
         w_cntNext  = '0;
         w_stepNext = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  w_codeNext = in_code;
                  w_stepNext = oneHot(in_code);
                  w_cntNext  = CNT_RELOAD;
               end
            end
            HOLD: begin
               if (r_cnt != '0) begin
                  w_cntNext = r_cnt - CNT_W'(1);
               end else if (scan) begin
                  w_codeNext = w_codeInc;
                  w_cntNext  = CNT_RELOAD;
`ifdef STEP_DECODER_GAP_EN
                  w_stepNext = '0;
`else
                  w_stepNext = oneHot(w_codeInc);
                  w_wrapNext = (r_code == 3'd7);
`endif
               end else begin
                  w_stepNext = '0;
               end
            end
`ifdef STEP_DECODER_GAP_EN
            // code already advanced on the way in, so code 0 here means we came from 7
            GAP: begin
               w_stepNext = oneHot(r_code);
               w_wrapNext = (r_code == 3'd0);
            end
`endif
            default: begin
               w_stepNext = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_code      <= 3'd0;
         r_cnt       <= '0;
         r_step      <= 8'd0;
         r_stepValid <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         r_code      <= w_codeNext;
         r_cnt       <= w_cntNext;
         r_step      <= w_stepNext;
         r_stepValid <= (w_stepNext != 8'd0);
         r_wrap      <= w_wrapNext;
      end
   end

   always_comb begin
      in_ready   = (r_state == IDLE);
      step       = r_step;
      step_valid = r_stepValid;
      wrap       = r_wrap;
   end

`ifndef SYNTHESIS
   a_stepOneHot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(step));
   a_validMatch : assert property (@(posedge clk) disable iff (!rst_n) step_valid == (step != 8'd0));
   a_holdStep   : assert property (@(posedge clk) disable iff (!rst_n)
                                   (r_state == HOLD) |-> (step == oneHot(r_code)));
`endif

endmodule

// File: tb/tb_step_decoder.sv
// Directed bench for step_decoder: three instances (DWELL 4, 2, 1) share one stimulus bus;
// each phase starts from a clear and checks only the instance it targets.
module tb_step_decoder;

   logic       clk;
   logic       rst_n;
   logic       inVld;
   logic [2:0] inCode;
   logic       scan;
   logic       clear;

   logic [7:0] step4, step2, step1;
   logic       valid4, valid2, valid1;
   logic       ready4, ready2, ready1;
   logic       wrap4, wrap2, wrap1;

   int compared = 0;
   int mismatched = 0;

   step_decoder #(.DWELL(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(inVld), .in_code(inCode), .in_ready(ready4),
      .scan(scan), .clear(clear), .step(step4), .step_valid(valid4), .wrap(wrap4));

   step_decoder #(.DWELL(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(inVld), .in_code(inCode), .in_ready(ready2),
      .scan(scan), .clear(clear), .step(step2), .step_valid(valid2), .wrap(wrap2));

   step_decoder #(.DWELL(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(inVld), .in_code(inCode), .in_ready(ready1),
      .scan(scan), .clear(clear), .step(step1), .step_valid(valid1), .wrap(wrap1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic [2:0] code;
      logic       scn;
      logic       clr;
      logic [7:0] expStep;
      logic       expValid;
      logic       expReady;
      logic       expWrap;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl [NV];

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkFlag(input string name, input logic act, input logic exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] c, input logic s, input logic cl);
      inVld  = v;
      inCode = c;
      scan   = s;
      clear  = cl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doClear();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
      tick();
      checkOutput("clear_step4", step4, 8'h00);
      checkOutput("clear_step2", step2, 8'h00);
      checkOutput("clear_step1", step1, 8'h00);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
   endtask

   // Invariants on every cycle, sampled mid-period
   always @(negedge clk) begin
      checkFlag("onehot4", $onehot0(step4), 1'b1);
      checkFlag("onehot2", $onehot0(step2), 1'b1);
      checkFlag("onehot1", $onehot0(step1), 1'b1);
      checkFlag("valid4_match", valid4, step4 != 8'h00);
      checkFlag("valid1_match", valid1, step1 != 8'h00);
   end

   logic [7:0] scanStep [];
   logic       scanWrap [];
   logic [7:0] expOne;

   initial begin
      // DWELL=4: single code 5 with in_valid held, then clear in HOLD, clear with handshake
      tbl[0]  = '{1'b1, 3'd5, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 3'd2, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 3'd2, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 3'd2, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 3'd2, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 3'd6, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      // code 1, scan raised only mid-dwell and dropped at expiry
      tbl[9]  = '{1'b1, 3'd1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

`ifdef STEP_DECODER_GAP_EN
      scanStep = '{8'h40, 8'h40, 8'h00, 8'h80, 8'h80, 8'h00, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02};
      scanWrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
      scanStep = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02, 8'h02};
      scanWrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif

      rst_n = 1'b0;
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
      #1;
      checkOutput("reset_step", step4, 8'h00);
      checkFlag("reset_valid", valid4, 1'b0);
      checkFlag("reset_ready", ready4, 1'b1);
      checkFlag("reset_wrap", wrap4, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         applyStimulus(tbl[i].vld, tbl[i].code, tbl[i].scn, tbl[i].clr);
         tick();
         checkOutput($sformatf("vec%0d_step", i), step4, tbl[i].expStep);
         checkFlag($sformatf("vec%0d_valid", i), valid4, tbl[i].expValid);
         checkFlag($sformatf("vec%0d_ready", i), ready4, tbl[i].expReady);
         checkFlag($sformatf("vec%0d_wrap", i), wrap4, tbl[i].expWrap);
      end

      // Scan across the 7 -> 0 wrap with DWELL=2
      doClear();
      applyStimulus(1'b1, 3'd6, 1'b1, 1'b0);
      for (int k = 0; k < scanStep.size(); k++) begin
         tick();
         if (k == 0) applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
         checkOutput($sformatf("scan%0d_step", k), step2, scanStep[k]);
         checkFlag($sformatf("scan%0d_wrap", k), wrap2, scanWrap[k]);
         checkFlag($sformatf("scan%0d_ready", k), ready2, 1'b0);
      end
      doClear();
      checkFlag("scan_clear_ready", ready2, 1'b1);

      // Asynchronous reset between edges in the middle of a hold
      applyStimulus(1'b1, 3'd5, 1'b0, 1'b0);
      tick();
      checkOutput("ar_hold", step4, 8'h20);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_step", step4, 8'h00);
      checkFlag("ar_valid", valid4, 1'b0);
      checkFlag("ar_ready", ready4, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
      tick();
      checkOutput("ar_fresh", step4, 8'h08);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
      doClear();

      // Every code with DWELL=1: one cycle of 1<<code, then idle
      for (int c = 0; c < 8; c++) begin
         expOne = 8'd1 << c;
         applyStimulus(1'b1, 3'(c), 1'b0, 1'b0);
         tick();
         checkOutput($sformatf("ex%0d_step", c), step1, expOne);
         checkFlag($sformatf("ex%0d_ready", c), ready1, 1'b0);
         applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
         tick();
         checkOutput($sformatf("ex%0d_idle", c), step1, 8'h00);
         checkFlag($sformatf("ex%0d_rdy", c), ready1, 1'b1);
      end

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
